key_debounce_scheduler: RTL

Time-shared debounce controller for up to 4 mechanical keys. It replaces one dedicated 1 ms / 10 ms delay timer per key with a single shared timer, allocated round-robin. Each key's raw input is synchronised and edge-detected, and the key is queued. A key that stays stable for the full debounce window gets a registered level and one-cycle press/release pulses. The block sits between the board key pins and the application logic, such as LED and mode control.

---
 rtl/key_sched_pkg.sv | 21 ++
 rtl/key_sync_edge.sv | 48 ++++
 rtl/key_debounce_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/key_sched_pkg.sv
// -----------------------------------------------------------------------------
// key_sched_pkg
// Shared definitions for the time-shared key debounce controller:
//   - FSM state encoding of the shared debounce timer
//   - key-count limit and the derived grant-index width
//   - widths of the 1 ms prescaler and the millisecond counter
// -----------------------------------------------------------------------------
package key_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TIMING = 2'd1,
        ST_COMMIT = 2'd2
    } sched_state_e;

    localparam int MAX_KEYS = 4;
    localparam int GIDX_W   = $clog2(MAX_KEYS);
    localparam int PRESC_W  = 16;
    localparam int MS_W     = 4;

endpackage

// File: rtl/key_sync_edge.sv
// -----------------------------------------------------------------------------
// key_sync_edge
// Front end for one raw key pin: two-flop synchroniser followed by an edge
// register. The edge strobe is registered, so it trails the synchronised level
// by one cycle.
//
// Ports:
//   CLK     in  system clock
//   RSTn    in  asynchronous active-low reset
//   i_key   in  raw, asynchronous key pin (idle high)
//   o_sync  out synchronised key level
//   o_edge  out one-cycle strobe for every change of the synchronised level
// -----------------------------------------------------------------------------
module key_sync_edge (
    input  logic CLK,
    input  logic RSTn,
    input  logic i_key,
    output logic o_sync,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_edge;

    // Synchroniser and edge register reset to the idle (released) level, so
    // leaving reset with the key released produces no spurious edge.
    // NOTE: every flop here uses non-blocking assignment; a blocking '=' would
    // collapse the shift chain into a single stage in simulation.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_edge <= 1'b0;
        end else begin
            r_meta <= i_key;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync ^ r_prev;
        end
    end

    assign o_sync = r_sync;
    assign o_edge = r_edge;

endmodule

// File: rtl/key_debounce_scheduler.sv
// -----------------------------------------------------------------------------
// key_debounce_scheduler
// Debounces up to four mechanical keys with a single shared timer. Every key
// change is queued as a pending request; a round-robin arbiter hands the timer
// to one key at a time. A key that stays unchanged for DEBOUNCE_MS ms gets its
// debounced level registered plus a one-cycle press or release pulse.
//
// Parameters:
//   NUM_KEYS     number of keys, 2..4
//   T1MS         prescaler terminal count, 1 ms = T1MS+1 cycles, 1..65535
//   DEBOUNCE_MS  stable time required, in ms, 1..15
//
// Ports:
//   CLK            in  system clock
//   RSTn           in  asynchronous active-low reset
//   Key_In         in  raw key pins, idle high, pressed = 0
//   Key_State      out debounced level, 1 = pressed
//   Press_Pulse    out one-cycle pulse on a debounced press
//   Release_Pulse  out one-cycle pulse on a debounced release
//   Busy           out shared timer allocated (TIMING or COMMIT)
//   Grant_Idx      out index of the key being timed; holds when idle
// -----------------------------------------------------------------------------
module key_debounce_scheduler
    import key_sched_pkg::*;
#(
    parameter int                 NUM_KEYS    = 4,
    parameter logic [PRESC_W-1:0] T1MS        = 16'd49_999,
    parameter logic [MS_W-1:0]    DEBOUNCE_MS = 4'd10
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [NUM_KEYS-1:0] Key_In,
    output logic [NUM_KEYS-1:0] Key_State,
    output logic [NUM_KEYS-1:0] Press_Pulse,
    output logic [NUM_KEYS-1:0] Release_Pulse,
    output logic                Busy,
    output logic [GIDX_W-1:0]   Grant_Idx
);

    sched_state_e        r_state;
    logic [NUM_KEYS-1:0] r_pend;
    logic [GIDX_W-1:0]   r_rr_ptr;
    logic [GIDX_W-1:0]   r_grant;
    logic [PRESC_W-1:0]  r_presc;
    logic [MS_W-1:0]     r_ms;
    logic [NUM_KEYS-1:0] r_key_state;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic                r_busy;

    logic [NUM_KEYS-1:0] w_sync;
    logic [NUM_KEYS-1:0] w_edge;
    logic [NUM_KEYS-1:0] w_pend_nxt;
    logic                w_found;
    logic [GIDX_W-1:0]   w_gnt;
    logic                w_active_edge;
    logic                w_lvl;

    // ---------------------------------------------------------------------
    // Per-key synchroniser and edge detector
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_sync_edge u_sync_edge (
            .CLK    (CLK),
            .RSTn   (RSTn),
            .i_key  (Key_In[g]),
            .o_sync (w_sync[g]),
            .o_edge (w_edge[g])
        );
    end

    assign w_active_edge = w_edge[r_grant];
    assign w_lvl         = ~w_sync[r_grant];

    // ---------------------------------------------------------------------
    // Round-robin arbiter: first pending key at or after r_rr_ptr. Scanning
    // offsets from the far end down lets the nearest pending key win.
    // NOTE: every signal driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    // ---------------------------------------------------------------------
    always_comb begin
        logic [GIDX_W-1:0] v_idx;
        w_found = 1'b0;
        w_gnt   = '0;
        v_idx   = '0;
        for (int off = NUM_KEYS - 1; off >= 0; off--) begin
            v_idx = GIDX_W'((int'(r_rr_ptr) + off) % NUM_KEYS);
            if (r_pend[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = v_idx;
            end
        end
    end

    // Pending requests: the grant clears the granted bit first, then any edge
    // sets its bit, so an edge landing on the grant cycle is never lost. The
    // key being timed absorbs its own edges as a window restart instead.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_state == ST_IDLE && w_found) begin
            w_pend_nxt[w_gnt] = 1'b0;
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_edge[i] && !(r_state == ST_TIMING && r_grant == GIDX_W'(i))) begin
                w_pend_nxt[i] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Shared-timer FSM with counters and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_presc     <= '0;
            r_ms        <= '0;
            r_key_state <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_press   <= '0;
            r_release <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_gnt;
                        r_presc <= '0;
                        r_ms    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_TIMING;
                    end
                end

                ST_TIMING: begin
                    if (w_active_edge) begin
                        // The key moved again: restart its window.
                        r_presc <= '0;
                        r_ms    <= '0;
                    end else if (r_presc == T1MS) begin
                        r_presc <= '0;
                        r_ms    <= r_ms + MS_W'(1);
                        // This wrap brings ms_cnt to DEBOUNCE_MS: window done.
                        if (r_ms == DEBOUNCE_MS - MS_W'(1)) begin
                            r_state <= ST_COMMIT;
                        end
                    end else begin
                        r_presc <= r_presc + PRESC_W'(1);
                    end
                end

                ST_COMMIT: begin
                    // A bounce that returned to the old level leaves no trace.
                    if (w_lvl != r_key_state[r_grant]) begin
                        r_key_state[r_grant] <= w_lvl;
                        if (w_lvl) begin
                            r_press[r_grant] <= 1'b1;
                        end else begin
                            r_release[r_grant] <= 1'b1;
                        end
                    end
                    r_rr_ptr <= GIDX_W'((int'(r_grant) + 1) % NUM_KEYS);
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Key_State     = r_key_state;
    assign Press_Pulse   = r_press;
    assign Release_Pulse = r_release;
    assign Busy          = r_busy;
    assign Grant_Idx     = r_grant;

endmodule
